// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter family.
//   arb_state_e : arbiter FSM encoding (IDLE / BUSY / RECOVER)
//   MAX_MASTERS : upper bound on the number of requesters an arbiter supports
//   rr_wrap     : wraps a rotated index back into 0..n-1
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } arb_state_e;

    localparam int MAX_MASTERS = 8;

    // v is at most 2*n-1 (last index plus an offset of 1..n), so one
    // conditional subtract is enough to wrap it.
    function automatic int rr_wrap(input int v, input int n);
        int r;
        if (v >= n) begin
            r = v - n;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotate-priority encoder.
// Searches req upward starting at last+1, wrapping N-1 -> 0, and reports the
// first set bit. The previous winner therefore has the lowest priority.
//   req    in  N       request vector
//   last   in  IW      index of the previous winner
//   onehot out N       one-hot winner (all 0 when no request)
//   idx    out IW      winner index (0 when no request)
//   any    out 1       at least one request present
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Rotating search for the first requester after the previous winner.
    always_comb begin
        int cand;
        cand   = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = rr_wrap(int'(last) + k, N);
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = IW'(cand);
                onehot[cand] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters.
// A master owns the slave for its whole cycle (m_cyc high); the owner's
// controls are muxed combinationally onto the slave and wb_ack is routed back
// to it alone. A watchdog ends a transfer whose strobe waits too long for an
// ack: the owner sees a one-cycle m_err pulse and the arbiter parks in RECOVER
// (slave side quiet) until that master drops m_cyc.
//   hclk, hresetn           clock, synchronous active-low reset
//   m_cyc/m_stb/m_we        per-master controls
//   m_addr/m_data_out       packed per-master address / write data
//   m_data_in               slave read data broadcast to every master
//   m_ack/m_err             per-master ack (combinational) / timeout (registered)
//   gnt                     registered one-hot grant, 0 when idle
//   wb_*                    slave-side port
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                              hclk,
    input  logic                              hresetn,
    input  logic [NUM_MASTERS-1:0]            m_cyc,
    input  logic [NUM_MASTERS-1:0]            m_stb,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
    output logic [DATA_WIDTH-1:0]             m_data_in,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic [NUM_MASTERS-1:0]            gnt,
    output logic                              wb_cyc,
    output logic                              wb_stb,
    output logic                              wb_we,
    output logic [ADDR_WIDTH-1:0]             wb_addr,
    output logic [DATA_WIDTH-1:0]             wb_data_out,
    input  logic [DATA_WIDTH-1:0]             wb_data_in,
    input  logic                              wb_ack
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic WD_EN = (TIMEOUT > 0);
    localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_MASTERS - 1);

    arb_state_e                state_q, state_d;
    logic [NUM_MASTERS-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]          last_q, last_d;
    logic [WDOG_W-1:0]         wdog_q, wdog_d;
    logic [NUM_MASTERS-1:0]    m_err_q, m_err_d;

    logic [NUM_MASTERS-1:0]    pick_onehot;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_any;

    logic                      sel_cyc;
    logic                      sel_stb;
    logic                      sel_we;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic                      wd_stall;
    logic                      wd_expire;

    wb_rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IDX_W)
    ) u_pick (
        .req    (m_cyc),
        .last   (last_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // last_q always names the current owner while a grant is held, so it
    // doubles as the mux select (cheaper than re-encoding the one-hot gnt).
    assign sel_cyc  = m_cyc[last_q];
    assign sel_stb  = m_stb[last_q];
    assign sel_we   = m_we[last_q];
    assign sel_addr = m_addr[int'(last_q) * ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = m_data_out[int'(last_q) * DATA_WIDTH +: DATA_WIDTH];

    // Strobe waiting on the slave; expiry needs the owner still in its cycle,
    // and a same-cycle ack always beats expiry because it clears wd_stall.
    assign wd_stall  = (state_q == BUSY) && sel_stb && !wb_ack;
    assign wd_expire = WD_EN && wd_stall && sel_cyc && (wdog_q == WDOG_LAST);

    // Slave-side mux and ack routing; only BUSY connects the owner.
    always_comb begin
        wb_cyc      = 1'b0;
        wb_stb      = 1'b0;
        wb_we       = 1'b0;
        wb_addr     = '0;
        wb_data_out = '0;
        m_ack       = '0;
        case (state_q)
            BUSY: begin
                wb_cyc        = sel_cyc;
                wb_stb        = sel_stb;
                wb_we         = sel_we;
                wb_addr       = sel_addr;
                wb_data_out   = sel_data;
                m_ack[last_q] = wb_ack;
            end
            default: begin
                wb_cyc = 1'b0;
            end
        endcase
    end

    // Next-state, grant, pointer and watchdog computation.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wdog_d  = '0;
        m_err_d = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    gnt_d   = pick_onehot;
                    last_d  = pick_idx;
                end else begin
                    gnt_d = '0;
                end
            end
            BUSY: begin
                if (!sel_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (wd_expire) begin
                    state_d = RECOVER;
                    m_err_d = gnt_q;
                end else if (WD_EN && wd_stall) begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end else begin
                    wdog_d = '0;
                end
            end
            RECOVER: begin
                if (!sel_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    state_d = RECOVER;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            wdog_q  <= '0;
            m_err_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            m_err_q <= m_err_d;
        end
    end

    assign gnt       = gnt_q;
    assign m_err     = m_err_q;
    assign m_data_in = wb_data_in;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios with literal expectations plus
// a bus-ownership model checked against every DUT output each cycle.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            hclk = 1'b0;
    logic            hresetn;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_data_out;
    logic [DW-1:0]   m_data_in;
    logic [N-1:0]    m_ack, m_err, gnt;
    logic            wb_cyc, wb_stb, wb_we;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data_out;
    logic [DW-1:0]   wb_data_in;
    logic            wb_ack;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: who owns the bus, whether that tenure timed out, fairness pointer.
    int md_owner = -1;
    int md_last  = N - 1;
    int md_cnt   = 0;
    bit md_rec   = 1'b0;
    int md_err   = -1;

    wb_rr_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TIMEOUT     (TO)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .m_cyc       (m_cyc),
        .m_stb       (m_stb),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_data_out  (m_data_out),
        .m_data_in   (m_data_in),
        .m_ack       (m_ack),
        .m_err       (m_err),
        .gnt         (gnt),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data_out (wb_data_out),
        .wb_data_in  (wb_data_in),
        .wb_ack      (wb_ack)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // Directed checks are taken 2 time units after the inputs settle.
    task automatic look();
        #2;
    endtask

    // Model update on each rising edge from the inputs seen at that edge.
    always @(posedge hclk) begin : mdl
        int o, l, c, e;
        bit r;
        o = md_owner; l = md_last; c = md_cnt; r = md_rec; e = -1;
        if (!hresetn) begin
            o = -1; l = N - 1; c = 0; r = 1'b0;
        end else if (o < 0) begin
            c = 0;
            for (int k = 1; k <= N; k++) begin
                if (o < 0 && m_cyc[(l + k) % N]) o = (l + k) % N;
            end
            if (o >= 0) l = o;
        end else if (r) begin
            if (!m_cyc[o]) begin o = -1; r = 1'b0; end
        end else begin
            if (!m_cyc[o]) begin
                o = -1; c = 0;
            end else if (m_stb[o] && !wb_ack) begin
                if (TO > 0 && c == TO - 1) begin e = o; r = 1'b1; c = 0; end
                else c = c + 1;
            end else begin
                c = 0;
            end
        end
        md_owner <= o;
        md_last  <= l;
        md_cnt   <= c;
        md_rec   <= r;
        md_err   <= e;
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge hclk) begin : cmp
        logic [N-1:0]  e_gnt, e_ack, e_err;
        logic          e_cyc, e_stb, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dout;
        e_gnt = '0; e_ack = '0; e_err = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_addr = '0; e_dout = '0;
        if (chk_en) begin
            if (md_owner >= 0) e_gnt[md_owner] = 1'b1;
            if (md_err >= 0) e_err[md_err] = 1'b1;
            if (md_owner >= 0 && !md_rec) begin
                e_cyc  = m_cyc[md_owner];
                e_stb  = m_stb[md_owner];
                e_we   = m_we[md_owner];
                e_addr = m_addr[md_owner*AW +: AW];
                e_dout = m_data_out[md_owner*DW +: DW];
                e_ack[md_owner] = wb_ack;
            end
            chk("mdl_gnt", 32'(gnt), 32'(e_gnt));
            chk("mdl_cyc", 32'(wb_cyc), 32'(e_cyc));
            chk("mdl_stb", 32'(wb_stb), 32'(e_stb));
            chk("mdl_we", 32'(wb_we), 32'(e_we));
            chk("mdl_addr", 32'(wb_addr), 32'(e_addr));
            chk("mdl_dout", 32'(wb_data_out), 32'(e_dout));
            chk("mdl_ack", 32'(m_ack), 32'(e_ack));
            chk("mdl_err", 32'(m_err), 32'(e_err));
            chk("mdl_din", 32'(m_data_in), 32'(wb_data_in));
        end
    end

    task automatic clear_masters();
        m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_data_out = '0;
        wb_ack = 1'b0;
    endtask

    task automatic pulse_reset();
        hresetn = 1'b0;
        step();
        hresetn = 1'b1;
    endtask

    initial begin
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        hresetn = 1'b0;
        clear_masters();
        wb_data_in = 8'h3C;

        // 1: reset held three cycles with every master requesting.
        m_cyc = 4'b1111;
        step();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_wbcyc", 32'(wb_cyc), 32'h0);
            chk("rst_ack", 32'(m_ack), 32'h0);
            if (i < 2) step();
        end
        hresetn = 1'b1;
        step();
        look();
        chk("rst_first_gnt", 32'(gnt), 32'h1);
        m_cyc = 4'b0000;
        step();

        // 2: master 1 writes A5 to address 2, slave acks on its third cycle.
        wb_data_in = 8'h5A;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        m_addr[3:2] = 2'h2; m_data_out[15:8] = 8'hA5;
        step();
        look();
        chk("s2_gnt", 32'(gnt), 32'h2);
        chk("s2_addr", 32'(wb_addr), 32'h2);
        chk("s2_data", 32'(wb_data_out), 32'hA5);
        chk("s2_we", 32'(wb_we), 32'h1);
        chk("s2_noack", 32'(m_ack), 32'h0);
        step();
        step();
        wb_ack = 1'b1;
        look();
        chk("s2_ack", 32'(m_ack), 32'h2);
        chk("s2_din", 32'(m_data_in), 32'h5A);
        step();
        clear_masters();
        look();
        chk("s2_ack_once", 32'(m_ack), 32'h0);
        chk("s2_gnt_held", 32'(gnt), 32'h2);
        step();
        look();
        chk("s2_gnt_drop", 32'(gnt), 32'h0);

        // 3: fairness with all masters requesting; owner drops on its ack.
        pulse_reset();
        m_cyc = 4'b1111; m_stb = 4'b1111;
        step();
        for (int t = 0; t < 5; t++) begin
            look();
            chk("s3_order", 32'(gnt), 32'(1 << exp_order[t]));
            wb_ack = 1'b1;
            m_cyc[exp_order[t]] = 1'b0;
            look();
            chk("s3_ack", 32'(m_ack), 32'(1 << exp_order[t]));
            step();
            wb_ack = 1'b0;
            m_cyc = 4'b1111;
            look();
            chk("s3_dead", 32'(gnt), 32'h0);
            step();
        end
        clear_masters();
        step();
        step();

        // 4: wrap from the top index, then re-grant of the only requester.
        pulse_reset();
        m_cyc = 4'b1001;
        step();
        look();
        chk("s4_wrap0", 32'(gnt), 32'h1);
        m_cyc = 4'b1000;
        step();
        step();
        look();
        chk("s4_then3", 32'(gnt), 32'h8);
        m_cyc = 4'b0001;
        step();
        step();
        m_cyc = 4'b0000;
        step();
        m_cyc = 4'b0001;
        step();
        look();
        chk("s4_regrant0", 32'(gnt), 32'h1);
        m_cyc = 4'b0000;
        step();

        // 5: master 2 strobes without an ack until the watchdog fires.
        m_cyc = 4'b0100; m_stb = 4'b0100; m_addr[5:4] = 2'h1;
        step();
        for (int i = 1; i <= TO; i++) begin
            look();
            chk("s5_noerr", 32'(m_err), 32'h0);
            chk("s5_cyc", 32'(wb_cyc), 32'h1);
            step();
        end
        wb_ack = 1'b1;
        look();
        chk("s5_err", 32'(m_err), 32'h4);
        chk("s5_cyc_off", 32'(wb_cyc), 32'h0);
        chk("s5_late_ack", 32'(m_ack), 32'h0);
        chk("s5_gnt_held", 32'(gnt), 32'h4);
        step();
        wb_ack = 1'b0;
        look();
        chk("s5_err_once", 32'(m_err), 32'h0);
        chk("s5_gnt_held2", 32'(gnt), 32'h4);
        m_cyc = 4'b0000; m_stb = 4'b0000;
        step();
        look();
        chk("s5_release", 32'(gnt), 32'h0);

        // 6: ack on the expiry cycle wins; then reset in the middle of BUSY.
        m_cyc = 4'b1000; m_stb = 4'b1000; m_we = 4'b1000;
        m_addr[7:6] = 2'h3; m_data_out[31:24] = 8'hC3;
        step();
        for (int i = 1; i < TO; i++) step();
        wb_ack = 1'b1;
        look();
        chk("s6_ack", 32'(m_ack), 32'h8);
        step();
        wb_ack = 1'b0;
        look();
        chk("s6_noerr", 32'(m_err), 32'h0);
        chk("s6_still_cyc", 32'(wb_cyc), 32'h1);
        step();
        step();
        hresetn = 1'b0;
        step();
        look();
        chk("s6_rst_gnt", 32'(gnt), 32'h0);
        chk("s6_rst_cyc", 32'(wb_cyc), 32'h0);
        chk("s6_rst_stb", 32'(wb_stb), 32'h0);
        chk("s6_rst_we", 32'(wb_we), 32'h0);
        chk("s6_rst_addr", 32'(wb_addr), 32'h0);
        chk("s6_rst_dout", 32'(wb_data_out), 32'h0);
        hresetn = 1'b1;
        clear_masters();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
